normalizador_redondeo: RTL and testbench
========================================

# normalizador_redondeo

Post-multiplication normalize, round and pack stage of the single-precision floating-point multiplier. It consumes the result sign from `xor_signo`, the biased exponent sum from the exponent adder and the 48-bit mantissa product from the mantissa multiplier. It produces the packed IEEE-754 binary32 result with exception flags behind a valid/ready handshake, and sits last in the multiplier datapath.

## Interface
- No parameters; fixed binary32 format (8-bit exponent, 23-bit fraction, bias 127).
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `signo`  in  1  result sign from `xor_signo`.
- `exp_sum`  in  10  two's-complement biased exponent, eA + eB − 127.
- `prod`  in  48  unsigned product of the two 24-bit mantissas with hidden bits set.
- `zero_in`  in  1  either operand is zero; forces a signed-zero result.
- `in_valid`  in  1  upstream operands valid.
- `in_ready`  out  1  stage accepts operands.
- `resultado`  out  32  packed binary32 result.
- `overflow`  out  1  result saturated to infinity.
- `underflow`  out  1  result flushed to zero.
- `inexact`  out  1  nonzero guard or sticky bits were discarded.
- `out_valid`  out  1  `resultado` and flags valid.
- `out_ready`  in  1  downstream consumes the result.

## Operation
- FSM states and transitions:
  - IDLE: `in_ready`=1. On `in_valid` && `in_ready`, register all inputs and go to NORM.
  - NORM:
    - If `prod[47]`=1: mantissa = `prod[46:24]`, guard = `prod[23]`, sticky = OR(`prod[22:0]`), exponent = `exp_sum`+1.
    - Otherwise: mantissa = `prod[45:23]`, guard = `prod[22]`, sticky = OR(`prod[21:0]`), exponent = `exp_sum`.
    - Go to ROUND.
  - ROUND:
    - Round to nearest, ties to even: increment when guard && (sticky || mantissa[0]).
    - Increment carry-out (mantissa all ones): mantissa = 0, exponent + 1.
    - Apply exceptions, register `resultado` and flags, go to OUT.
  - OUT: `out_valid`=1. When `out_ready`=1, go to IDLE.
- Exception priority, highest first:
  - `zero_in`: result {signo, 31'b0}; all flags 0.
  - Final exponent ≥ 255: {signo, 8'hFF, 23'b0}; `overflow`=1, `inexact`=1.
  - Final exponent ≤ 0: {signo, 31'b0}; `underflow`=1, `inexact`=1. No subnormals.
  - Otherwise: {signo, exponent[7:0], mantissa}; `inexact` = guard || sticky.
- Exponent arithmetic is 10-bit signed throughout. Inputs with `prod[47:46]`=00 are out of contract and need not be handled.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `resultado`=0, `overflow`=0, `underflow`=0, `inexact`=0, state IDLE.
- Latency: accept in cycle N; cycle N+1 is NORM, cycle N+2 is ROUND, `out_valid`=1 in cycle N+3.
- Throughput: one operation per 4 cycles with `out_ready` held high.
- `in_ready` is high only in IDLE. Inputs presented outside IDLE are ignored.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `resultado` and flags hold stable.
- `out_ready` asserted while not in OUT has no effect.
- `rst` mid-operation: the next edge returns the block to reset values and the in-flight operation is dropped. `rst` has priority over the handshake.
- Flags are registered with `resultado` and change only on entry to OUT or on reset.

## Test plan
- 1.5×1.5: `signo`=0, `exp_sum`=127, `prod`=48'h900000000000 -> after 3 cycles `resultado`=32'h40100000; flags 0. Repeat with `signo`=1 -> 32'hC0100000.
- Ties: `prod`=48'h400000C00000, `exp_sum`=127 -> 32'h3F800002, `inexact`=1. Then `prod`=48'h400000400000 -> 32'h3F800000, `inexact`=1.
- Rounding carry: `prod`=48'h7FFFFFC00000, `exp_sum`=127 -> 32'h40000000, `inexact`=1.
- Exceptions:
  - `exp_sum`=254, `prod`=48'h800000000000 -> 32'h7F800000, `overflow`=1.
  - `exp_sum`=0, `prod`=48'h400000000000, `signo`=1 -> 32'h80000000, `underflow`=1.
  - `zero_in`=1 with the overflow operands -> 32'h00000000, flags 0.
- Backpressure:
  - Hold `out_ready`=0 for 5 cycles in OUT -> result stable and `in_ready`=0 throughout.
  - Assert `out_ready` -> next cycle IDLE, `in_ready`=1, `out_valid`=0.
- Reset: assert `rst` one cycle while in ROUND -> next cycle `out_valid`=0, `in_ready`=1, `resultado`=0, and no result ever emitted for that operation.

Source files
------------

// File: rtl/normalizador_redondeo_if.sv
// Handshake bundle between the multiplier datapath and the normalize/round/pack
// stage: operand side (signo, exp_sum, prod, zero_in, in_valid/in_ready) and
// result side (resultado, flags, out_valid/out_ready).
interface normalizador_redondeo_if;
    logic        signo;
    logic [9:0]  exp_sum;
    logic [47:0] prod;
    logic        zero_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] resultado;
    logic        overflow;
    logic        underflow;
    logic        inexact;
    logic        out_valid;
    logic        out_ready;

    // Upstream/downstream view: drives operands and consumes results.
    modport master (
        output signo, exp_sum, prod, zero_in, in_valid, out_ready,
        input  in_ready, resultado, overflow, underflow, inexact, out_valid
    );

    // Stage view: accepts operands and produces the packed result.
    modport slave (
        input  signo, exp_sum, prod, zero_in, in_valid, out_ready,
        output in_ready, resultado, overflow, underflow, inexact, out_valid
    );
endinterface

// File: rtl/normalizador_redondeo.sv
// Normalize, round (nearest, ties to even) and pack stage of the binary32
// multiplier. Four-state sequence IDLE -> NORM -> ROUND -> OUT; the result and
// flags are registered on entry to OUT and held until the consumer takes them.
module normalizador_redondeo (
    input  logic                         clk,
    input  logic                         rst,
    normalizador_redondeo_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t state_r;
    state_t state_s;

    // Captured operands
    logic               signo_r;
    logic               zero_r;
    logic signed [9:0]  exp_r;
    logic [47:0]        prod_r;

    // Normalized mantissa and rounding bits
    logic [22:0]        mant_r;
    logic               guard_r;
    logic               sticky_r;

    // Registered outputs
    logic [31:0]        resultado_r;
    logic               overflow_r;
    logic               underflow_r;
    logic               inexact_r;
    logic               in_ready_r;
    logic               out_valid_r;

    // Combinational helpers
    logic [22:0]        norm_mant_s;
    logic               norm_guard_s;
    logic               norm_sticky_s;
    logic signed [9:0]  norm_exp_s;
    logic               round_up_s;
    logic [23:0]        mant_inc_s;
    logic signed [9:0]  exp_fin_s;
    logic [31:0]        res_s;
    logic               overflow_s;
    logic               underflow_s;
    logic               inexact_s;

    // OR of the bits below the guard position; true when anything nonzero is lost.
    function automatic logic sticky_of(input logic [22:0] bits);
        sticky_of = |bits;
    endfunction

    // State register; reset has priority over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic for the IDLE/NORM/ROUND/OUT sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    state_s = NORM;
                end else begin
                    state_s = IDLE;
                end
            end
            NORM:  state_s = ROUND;
            ROUND: state_s = OUT;
            OUT: begin
                if (bus.out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = OUT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Normalization: a product in [2,4) shifts one place right and bumps the exponent.
    always_comb begin
        norm_mant_s   = 23'd0;
        norm_guard_s  = 1'b0;
        norm_sticky_s = 1'b0;
        norm_exp_s    = exp_r;
        if (prod_r[47]) begin
            norm_mant_s   = prod_r[46:24];
            norm_guard_s  = prod_r[23];
            norm_sticky_s = sticky_of(prod_r[22:0]);
            norm_exp_s    = exp_r + 10'sd1;
        end else begin
            norm_mant_s   = prod_r[45:23];
            norm_guard_s  = prod_r[22];
            norm_sticky_s = sticky_of({1'b0, prod_r[21:0]});
            norm_exp_s    = exp_r;
        end
    end

    // Rounding plus exception selection; zero operand beats overflow beats underflow.
    always_comb begin
        round_up_s  = guard_r & (sticky_r | mant_r[0]);
        mant_inc_s  = {1'b0, mant_r} + {23'd0, round_up_s};
        exp_fin_s   = exp_r + $signed({9'd0, mant_inc_s[23]});
        res_s       = 32'd0;
        overflow_s  = 1'b0;
        underflow_s = 1'b0;
        inexact_s   = 1'b0;
        if (zero_r) begin
            res_s = {signo_r, 31'd0};
        end else if (exp_fin_s >= 10'sd255) begin
            res_s      = {signo_r, 8'hFF, 23'd0};
            overflow_s = 1'b1;
            inexact_s  = 1'b1;
        end else if (exp_fin_s <= 10'sd0) begin
            res_s       = {signo_r, 31'd0};
            underflow_s = 1'b1;
            inexact_s   = 1'b1;
        end else begin
            // On a rounding carry the low 23 bits of mant_inc_s are already zero.
            res_s     = {signo_r, exp_fin_s[7:0], mant_inc_s[22:0]};
            inexact_s = guard_r | sticky_r;
        end
    end

    // Datapath registers: capture in IDLE, normalize in NORM, pack in ROUND.
    always_ff @(posedge clk) begin
        if (rst) begin
            signo_r     <= 1'b0;
            zero_r      <= 1'b0;
            exp_r       <= 10'sd0;
            prod_r      <= 48'd0;
            mant_r      <= 23'd0;
            guard_r     <= 1'b0;
            sticky_r    <= 1'b0;
            resultado_r <= 32'd0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            inexact_r   <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == OUT);
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        signo_r <= bus.signo;
                        zero_r  <= bus.zero_in;
                        exp_r   <= $signed(bus.exp_sum);
                        prod_r  <= bus.prod;
                    end
                end
                NORM: begin
                    mant_r   <= norm_mant_s;
                    guard_r  <= norm_guard_s;
                    sticky_r <= norm_sticky_s;
                    exp_r    <= norm_exp_s;
                end
                ROUND: begin
                    resultado_r <= res_s;
                    overflow_r  <= overflow_s;
                    underflow_r <= underflow_s;
                    inexact_r   <= inexact_s;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.resultado = resultado_r;
    assign bus.overflow  = overflow_r;
    assign bus.underflow = underflow_r;
    assign bus.inexact   = inexact_r;

endmodule

// File: tb/tb_normalizador_redondeo.sv
// Directed bench for normalizador_redondeo: hand-computed binary32 results,
// latency, backpressure and mid-operation reset.
module tb_normalizador_redondeo;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    normalizador_redondeo_if bus();

    normalizador_redondeo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    // Present one operand set; returns just after the accepting edge.
    task automatic start_op(input string tag, input logic s, input logic [9:0] e,
                            input logic [47:0] p, input logic z);
        @(negedge clk);
        check({tag, " in_ready"}, {63'd0, bus.in_ready}, 64'd1);
        bus.signo    = s;
        bus.exp_sum  = e;
        bus.prod     = p;
        bus.zero_in  = z;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.prod     = 48'hFFFF_FFFF_FFFF;
        bus.exp_sum  = 10'd300;
    endtask

    // Wait (bounded) for out_valid and check it arrives in cycle N+3.
    task automatic wait_out(input string tag);
        int lat;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd3);
    endtask

    task automatic check_out(input string tag, input logic [31:0] res, input logic [2:0] flags);
        check({tag, " resultado"}, {32'd0, bus.resultado}, {32'd0, res});
        check({tag, " ovf/unf/inx"}, {61'd0, bus.overflow, bus.underflow, bus.inexact}, {61'd0, flags});
    endtask

    task automatic release_out(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check({tag, " out_valid after take"}, {63'd0, bus.out_valid}, 64'd0);
        check({tag, " in_ready after take"}, {63'd0, bus.in_ready}, 64'd1);
    endtask

    task automatic do_op(input string tag, input logic s, input logic [9:0] e,
                         input logic [47:0] p, input logic z,
                         input logic [31:0] res, input logic [2:0] flags);
        bus.out_ready = 1'b1;
        start_op(tag, s, e, p, z);
        wait_out(tag);
        check_out(tag, res, flags);
        release_out(tag);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        bus.signo     = 1'b0;
        bus.exp_sum   = 10'd0;
        bus.prod      = 48'd0;
        bus.zero_in   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("reset in_ready", {63'd0, bus.in_ready}, 64'd1);
        check_out("reset", 32'h0000_0000, 3'b000);
        rst = 1'b0;

        // flags ordered {overflow, underflow, inexact}
        do_op("1.5x1.5",      1'b0, 10'd127, 48'h9000_0000_0000, 1'b0, 32'h4010_0000, 3'b000);
        do_op("-1.5x1.5",     1'b1, 10'd127, 48'h9000_0000_0000, 1'b0, 32'hC010_0000, 3'b000);
        do_op("tie odd up",   1'b0, 10'd127, 48'h4000_00C0_0000, 1'b0, 32'h3F80_0002, 3'b001);
        do_op("tie even",     1'b0, 10'd127, 48'h4000_0040_0000, 1'b0, 32'h3F80_0000, 3'b001);
        do_op("round carry",  1'b0, 10'd127, 48'h7FFF_FFC0_0000, 1'b0, 32'h4000_0000, 3'b001);
        do_op("sticky only",  1'b0, 10'd100, 48'h8000_0000_0001, 1'b0, 32'h3280_0000, 3'b001);
        do_op("max normal",   1'b0, 10'd254, 48'h4000_0000_0000, 1'b0, 32'h7F00_0000, 3'b000);
        do_op("overflow",     1'b0, 10'd254, 48'h8000_0000_0000, 1'b0, 32'h7F80_0000, 3'b101);
        do_op("carry ovf",    1'b1, 10'd253, 48'hFFFF_FF80_0000, 1'b0, 32'hFF80_0000, 3'b101);
        do_op("underflow",    1'b1, 10'd0,   48'h4000_0000_0000, 1'b0, 32'h8000_0000, 3'b011);
        do_op("neg exp",      1'b0, 10'h3FB, 48'h4000_0000_0000, 1'b0, 32'h0000_0000, 3'b011);
        do_op("zero_in",      1'b0, 10'd254, 48'h8000_0000_0000, 1'b1, 32'h0000_0000, 3'b000);
        do_op("neg zero_in",  1'b1, 10'd127, 48'h9000_0000_0000, 1'b1, 32'h8000_0000, 3'b000);

        // Backpressure with a competing operand presented while busy
        bus.out_ready = 1'b0;
        start_op("bp", 1'b0, 10'd127, 48'h9000_0000_0000, 1'b0);
        wait_out("bp");
        check_out("bp", 32'h4010_0000, 3'b000);
        bus.signo    = 1'b1;
        bus.exp_sum  = 10'd254;
        bus.prod     = 48'h8000_0000_0000;
        bus.zero_in  = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp hold resultado", {32'd0, bus.resultado}, 64'h4010_0000);
            check("bp hold out_valid", {63'd0, bus.out_valid}, 64'd1);
            check("bp in_ready low", {63'd0, bus.in_ready}, 64'd0);
        end
        bus.in_valid = 1'b0;
        release_out("bp");

        // Reset while in ROUND drops the operation
        bus.out_ready = 1'b1;
        start_op("rst", 1'b0, 10'd127, 48'h9000_0000_0000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst in_ready", {63'd0, bus.in_ready}, 64'd1);
        check_out("rst", 32'h0000_0000, 3'b000);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst no emission", {63'd0, bus.out_valid}, 64'd0);
        end

        do_op("after rst", 1'b1, 10'd127, 48'h4000_00C0_0000, 1'b0, 32'hBF80_0002, 3'b001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
